// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks WIDTH-bit operands LSB first,
// with the carry held in a register between bit steps.

module fadder_1bit_df (
   output logic S,
   output logic Cout,
   input  logic A,
   input  logic B,
   input  logic Cin
);
   assign S    = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] sa, sb, ps;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             s_bit, c_bit;
   logic             load, step, last;

   fadder_1bit_df u_cell (
      .S    (s_bit),
      .Cout (c_bit),
      .A    (sa[0]),
      .B    (sb[0]),
      .Cin  (c)
   );

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: if (start) begin
            load       = 1'b1;
            state_next = RUN;
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         sa    <= '0;
         sb    <= '0;
         ps    <= '0;
         c     <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         // Flags follow the next state so they are registered, not decoded.
         busy  <= (state_next == RUN);
         done  <= (state_next == DONE);
         if (load) begin
            sa  <= a;
            sb  <= b;
            c   <= cin;
            cnt <= '0;
         end
         if (step) begin
            ps  <= {s_bit, ps[WIDTH-1:1]};
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            c   <= c_bit;
            cnt <= cnt + CW'(1);
         end
         if (last) begin
            sum  <= {s_bit, ps[WIDTH-1:1]};
            cout <= c_bit;
         end
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH = 8 and WIDTH = 3 sharing one clock/reset.

module tb_serial_adder_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start8 = 1'b0, start3 = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       cin = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;
   logic       busy3, done3, cout3;
   logic [2:0] sum3;
   int         tests = 0, failed = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .cin(cin),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder_ctrl #(.WIDTH(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .a(a[2:0]), .b(b[2:0]), .cin(cin),
      .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One full operation on the selected instance; busy/done are checked every cycle.
   task automatic run_op(input bit w3, input logic [7:0] op_a, input logic [7:0] op_b,
                         input logic op_cin, input logic [8:0] exp, input string tag);
      int w;
      w = w3 ? 3 : 8;
      a = op_a; b = op_b; cin = op_cin;
      if (w3) start3 = 1'b1; else start8 = 1'b1;
      tick();
      start3 = 1'b0; start8 = 1'b0;
      a = ~op_a; b = ~op_b; cin = ~op_cin;
      for (int k = 0; k < w; k++) begin
         check({tag, " busy"}, w3 ? busy3 : busy8, 1);
         check({tag, " done early"}, w3 ? done3 : done8, 0);
         tick();
      end
      check({tag, " done"}, w3 ? done3 : done8, 1);
      check({tag, " busy at done"}, w3 ? busy3 : busy8, 0);
      check({tag, " result"}, w3 ? {5'd0, cout3, sum3} : {cout8, sum8}, exp);
      tick();
      check({tag, " done drop"}, w3 ? done3 : done8, 0);
      check({tag, " idle busy"}, w3 ? busy3 : busy8, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1, t2, n;

      // Reset with start held high and arbitrary operands.
      rst = 1'b1; start8 = 1'b1; start3 = 1'b1; a = 8'hA7; b = 8'h6D; cin = 1'b1;
      tick(); tick();
      check("rst busy8", busy8, 0);
      check("rst done8", done8, 0);
      check("rst sum8", sum8, 8'h00);
      check("rst cout8", cout8, 0);
      check("rst busy3", busy3, 0);
      check("rst result3", {cout3, sum3}, 4'h0);
      rst = 1'b0; start8 = 1'b0; start3 = 1'b0;
      tick();
      check("post-rst busy8", busy8, 0);

      // Basic add and carry chain.
      run_op(0, 8'h3C, 8'h5A, 1'b0, 9'h096, "add 3C+5A");
      run_op(0, 8'hFF, 8'h01, 1'b0, 9'h100, "add FF+01");
      run_op(0, 8'hFF, 8'hFF, 1'b1, 9'h1FF, "add FF+FF+1");
      run_op(0, 8'h00, 8'h00, 1'b1, 9'h001, "add 00+00+1");
      run_op(0, 8'hA5, 8'h5A, 1'b1, 9'h100, "add A5+5A+1");
      run_op(0, 8'h12, 8'h34, 1'b0, 9'h046, "add 12+34");
      run_op(0, 8'h7F, 8'h01, 1'b1, 9'h081, "add 7F+01+1");

      // Start held high: second op ignored until IDLE, operands free to change.
      a = 8'h3C; b = 8'h5A; cin = 1'b0; start8 = 1'b1;
      tick();
      a = 8'h11; b = 8'h22;
      n = 0;
      while (!done8 && n < 20) begin tick(); n++; end
      check("hold first done latency", n, 8);
      check("hold first sum", sum8, 8'h96);
      t1 = cyc;
      tick();
      check("hold done pulse width", done8, 0);
      tick();
      check("hold second accepted", busy8, 1);
      a = 8'h55; b = 8'h55;
      n = 0;
      tick();
      while (!done8 && n < 20) begin
         check("hold sum during run", sum8, 8'h96);
         tick(); n++;
      end
      t2 = cyc;
      check("hold done spacing", t2 - t1, 10);
      check("hold second result", {cout8, sum8}, 9'h033);
      start8 = 1'b0;
      tick(); tick();

      // Abort mid-operation.
      a = 8'h80; b = 8'h80; cin = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      check("abort still busy", busy8, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort busy", busy8, 0);
      check("abort sum", sum8, 8'h00);
      check("abort cout", cout8, 0);
      for (int k = 0; k < 12; k++) begin
         check("abort no done", done8, 0);
         tick();
      end
      run_op(0, 8'h0F, 8'hF1, 1'b0, 9'h100, "add 0F+F1 after abort");

      // Narrow instance.
      run_op(1, 8'h05, 8'h06, 1'b0, 9'h00B, "w3 5+6");
      run_op(1, 8'h07, 8'h07, 1'b1, 9'h00F, "w3 7+7+1");
      run_op(1, 8'h02, 8'h01, 1'b1, 9'h004, "w3 2+1+1");
      run_op(1, 8'h03, 8'h02, 1'b0, 9'h005, "w3 3+2");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
